mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline boundary for single- or dual-issue cores. Carries per-lane writeback bundles (lane valid, regwrite, rd, rd data) across a valid/ready handshake, so the register-file side can back-pressure. Adds flush, x0-write suppression, same-rd write collapse across lanes, and a retired-instruction counter. Sits between the MEM stage and the register-file write ports; its outputs also drive the WB forwarding path.

---
 rtl/mem_wb_pipe_pkg.sv | 28 ++
 rtl/wb_skid_buf.sv | 83 ++++++++
 rtl/mem_wb_pipe.sv | 106 ++++++++++
 tb/tb_mem_wb_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared types and helpers for the MEM->WB pipeline boundary.
package mem_wb_pipe_pkg;

  localparam int unsigned MAX_LANES = 2;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Writeback regwrite cleanup over up to two lanes (lane0 in bit 0).
  // Drops writes to x0 or from empty lanes; when both lanes target the same
  // register the younger lane1 wins.
  function automatic logic [MAX_LANES-1:0] wb_sanitise(
    input logic [MAX_LANES-1:0] lane_valid,
    input logic [MAX_LANES-1:0] regwrite,
    input logic [MAX_LANES-1:0] rd_nonzero,
    input logic                 same_rd
  );
    logic [MAX_LANES-1:0] rw;
    rw = regwrite & lane_valid & rd_nonzero;
    if ((rw == 2'b11) && same_rd) rw[0] = 1'b0;
    return rw;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic two-entry valid/ready skid buffer with flush. Entry M drives the
// outputs, entry S absorbs one extra beat so in_ready can be registered.
module wb_skid_buf
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   r_state;
  logic [W-1:0] r_m;
  logic [W-1:0] r_s;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         w_accept;
  logic         w_deliver;

  assign w_accept  = in_valid & r_in_ready & ~flush;
  assign w_deliver = r_out_valid & out_ready;

  // Occupancy FSM with data movement; flush empties but keeps entry contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= BUF_EMPTY;
      r_m         <= '0;
      r_s         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= BUF_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_accept) begin
            r_m         <= in_data;
            r_state     <= BUF_ONE;
            r_out_valid <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (w_accept && w_deliver) begin
            r_m <= in_data;
          end else if (w_accept) begin
            r_s        <= in_data;
            r_state    <= BUF_FULL;
            r_in_ready <= 1'b0;
          end else if (w_deliver) begin
            r_state     <= BUF_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        BUF_FULL: begin
          if (w_deliver) begin
            r_m        <= r_s;
            r_state    <= BUF_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= BUF_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_m;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline boundary: sanitises per-lane writeback bundles, buffers
// them in a skid buffer and counts retired instructions.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        lane_valid_in,
  input  logic [LANES-1:0]        regwrite_in,
  input  logic [LANES*RA_W-1:0]   rd_in,
  input  logic [LANES*XLEN-1:0]   rd_data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        lane_valid_out,
  output logic [LANES-1:0]        regwrite_out,
  output logic [LANES*RA_W-1:0]   rd_out,
  output logic [LANES*XLEN-1:0]   rd_data_out,
  output logic [CNT_W-1:0]        retire_cnt
);

  typedef struct packed {
    logic [LANES-1:0]      lane_valid;
    logic [LANES-1:0]      regwrite;
    logic [LANES*RA_W-1:0] rd;
    logic [LANES*XLEN-1:0] data;
  } wb_beat_t;

  localparam int unsigned BEAT_W = $bits(wb_beat_t);

  logic [LANES-1:0]     w_rd_nz;
  logic                 w_same_rd;
  logic [MAX_LANES-1:0] w_rw_clean;
  logic [MAX_LANES-1:0] w_lvo2;
  logic [CNT_W-1:0]     w_pop;
  logic                 w_deliver;
  wb_beat_t             w_in_beat;
  wb_beat_t             w_m_beat;
  logic [CNT_W-1:0]     r_retire_cnt;

  // Per-lane "rd is not x0" flags.
  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    assign w_rd_nz[g] = |rd_in[g*RA_W +: RA_W];
  end

  // Same-destination detect only exists with two lanes.
  if (LANES == 2) begin : g_dual
    assign w_same_rd = (rd_in[RA_W-1:0] == rd_in[2*RA_W-1:RA_W]);
  end else begin : g_single
    assign w_same_rd = 1'b0;
  end

  assign w_rw_clean = wb_sanitise(2'(lane_valid_in), 2'(regwrite_in), 2'(w_rd_nz), w_same_rd);

  // Bundle offered to the buffer, already sanitised.
  always_comb begin
    w_in_beat            = '0;
    w_in_beat.lane_valid = lane_valid_in;
    w_in_beat.regwrite   = LANES'(w_rw_clean);
    w_in_beat.rd         = rd_in;
    w_in_beat.data       = rd_data_in;
  end

  wb_skid_buf #(
    .W (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_m_beat)
  );

  assign lane_valid_out = w_m_beat.lane_valid & {LANES{out_valid}};
  assign regwrite_out   = w_m_beat.regwrite & {LANES{out_valid}};
  assign rd_out         = w_m_beat.rd;
  assign rd_data_out    = w_m_beat.data;

  assign w_deliver = out_valid & out_ready;
  assign w_lvo2    = 2'(lane_valid_out);
  assign w_pop     = CNT_W'(w_lvo2[0]) + CNT_W'(w_lvo2[1]);

  // Retired-instruction counter; a delivery during flush still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (w_deliver) begin
      r_retire_cnt <= r_retire_cnt + w_pop;
    end
  end

  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: single-lane and dual-lane instances.
module tb_mem_wb_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Single-lane instance, 32-bit counter
  logic        f1 = 0, iv1 = 0, ir1, ov1, or1 = 0;
  logic [0:0]  lv1 = 0, rw1 = 0, lvo1, rwo1;
  logic [4:0]  rd1 = 0, rdo1;
  logic [31:0] d1 = 0, do1, cnt1;

  // Dual-lane instance, 4-bit counter
  logic        f2 = 0, iv2 = 0, ir2, ov2, or2 = 0;
  logic [1:0]  lv2 = 0, rw2 = 0, lvo2, rwo2;
  logic [9:0]  rd2 = 0, rdo2;
  logic [63:0] d2 = 0, do2;
  logic [3:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_pipe #(.XLEN(32), .RA_W(5), .LANES(1), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .flush(f1), .in_valid(iv1), .in_ready(ir1),
    .lane_valid_in(lv1), .regwrite_in(rw1), .rd_in(rd1), .rd_data_in(d1),
    .out_valid(ov1), .out_ready(or1), .lane_valid_out(lvo1), .regwrite_out(rwo1),
    .rd_out(rdo1), .rd_data_out(do1), .retire_cnt(cnt1)
  );

  mem_wb_pipe #(.XLEN(32), .RA_W(5), .LANES(2), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .flush(f2), .in_valid(iv2), .in_ready(ir2),
    .lane_valid_in(lv2), .regwrite_in(rw2), .rd_in(rd2), .rd_data_in(d2),
    .out_valid(ov2), .out_ready(or2), .lane_valid_out(lvo2), .regwrite_out(rwo2),
    .rd_out(rdo2), .rd_data_out(do2), .retire_cnt(cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_ov1: got %0h want 0", ov1); end
    n_vec++; if (lvo1 !== 1'b0) begin n_err++; $display("FAIL reset_lvo1: got %0h want 0", lvo1); end
    n_vec++; if (rwo1 !== 1'b0) begin n_err++; $display("FAIL reset_rwo1: got %0h want 0", rwo1); end
    n_vec++; if (rdo1 !== 5'd0) begin n_err++; $display("FAIL reset_rdo1: got %0h want 0", rdo1); end
    n_vec++; if (do1 !== 32'd0) begin n_err++; $display("FAIL reset_do1: got %0h want 0", do1); end
    n_vec++; if (cnt1 !== 32'd0) begin n_err++; $display("FAIL reset_cnt1: got %0h want 0", cnt1); end
    n_vec++; if (cnt2 !== 4'd0) begin n_err++; $display("FAIL reset_cnt2: got %0h want 0", cnt2); end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_vec++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL reset_ir1: got %0h want 1", ir1); end
    n_vec++; if (ir2 !== 1'b1) begin n_err++; $display("FAIL reset_ir2: got %0h want 1", ir2); end
    n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL reset_ov2: got %0h want 0", ov2); end
  endtask

  task automatic test_single_beat();
    or1 = 1; iv1 = 1; lv1 = 1; rw1 = 1; rd1 = 5'd5; d1 = 32'hDEADBEEF;
    step();
    iv1 = 0;
    n_vec++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL single_ov: got %0h want 1", ov1); end
    n_vec++; if (rdo1 !== 5'd5) begin n_err++; $display("FAIL single_rd: got %0h want 5", rdo1); end
    n_vec++; if (do1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %0h want deadbeef", do1); end
    n_vec++; if (rwo1 !== 1'b1) begin n_err++; $display("FAIL single_rw: got %0h want 1", rwo1); end
    n_vec++; if (cnt1 !== 32'd0) begin n_err++; $display("FAIL single_cnt_pre: got %0h want 0", cnt1); end
    step();
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL single_ov_after: got %0h want 0", ov1); end
    n_vec++; if (cnt1 !== 32'd1) begin n_err++; $display("FAIL single_cnt: got %0h want 1", cnt1); end
    n_vec++; if (rwo1 !== 1'b0) begin n_err++; $display("FAIL single_rw_gated: got %0h want 0", rwo1); end
    n_vec++; if (rdo1 !== 5'd5) begin n_err++; $display("FAIL single_rd_hold: got %0h want 5", rdo1); end
  endtask

  task automatic test_back_pressure();
    or1 = 0; iv1 = 1; rd1 = 5'd1; d1 = 32'hAAAA0001;
    step();
    n_vec++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL bp_ir_one: got %0h want 1", ir1); end
    rd1 = 5'd2; d1 = 32'hBBBB0002;
    step();
    n_vec++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL bp_ir_full: got %0h want 0", ir1); end
    n_vec++; if (rdo1 !== 5'd1) begin n_err++; $display("FAIL bp_rd_a: got %0h want 1", rdo1); end
    rd1 = 5'd3; d1 = 32'hCCCC0003;
    step();
    n_vec++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL bp_ir_held: got %0h want 0", ir1); end
    n_vec++; if (rdo1 !== 5'd1) begin n_err++; $display("FAIL bp_rd_stable: got %0h want 1", rdo1); end
    n_vec++; if (do1 !== 32'hAAAA0001) begin n_err++; $display("FAIL bp_data_stable: got %0h want aaaa0001", do1); end
    n_vec++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL bp_ov_stable: got %0h want 1", ov1); end
    or1 = 1;
    step();
    n_vec++; if (rdo1 !== 5'd2) begin n_err++; $display("FAIL bp_rd_b: got %0h want 2", rdo1); end
    n_vec++; if (do1 !== 32'hBBBB0002) begin n_err++; $display("FAIL bp_data_b: got %0h want bbbb0002", do1); end
    n_vec++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL bp_ir_reopen: got %0h want 1", ir1); end
    step();
    iv1 = 0;
    n_vec++; if (rdo1 !== 5'd3) begin n_err++; $display("FAIL bp_rd_c: got %0h want 3", rdo1); end
    n_vec++; if (do1 !== 32'hCCCC0003) begin n_err++; $display("FAIL bp_data_c: got %0h want cccc0003", do1); end
    step();
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL bp_ov_drain: got %0h want 0", ov1); end
    n_vec++; if (cnt1 !== 32'd4) begin n_err++; $display("FAIL bp_cnt: got %0h want 4", cnt1); end
  endtask

  task automatic test_flush();
    or1 = 0; iv1 = 1; lv1 = 1; rw1 = 1; rd1 = 5'd10; d1 = 32'hF0F0F0F0;
    step();
    rd1 = 5'd11; d1 = 32'hF1F1F1F1;
    step();
    rd1 = 5'd12; d1 = 32'hF2F2F2F2; f1 = 1;
    step();
    f1 = 0; iv1 = 0;
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL flush_ov: got %0h want 0", ov1); end
    n_vec++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL flush_ir: got %0h want 1", ir1); end
    n_vec++; if (lvo1 !== 1'b0) begin n_err++; $display("FAIL flush_lvo: got %0h want 0", lvo1); end
    n_vec++; if (rwo1 !== 1'b0) begin n_err++; $display("FAIL flush_rwo: got %0h want 0", rwo1); end
    n_vec++; if (rdo1 !== 5'd10) begin n_err++; $display("FAIL flush_rd_hold: got %0h want a", rdo1); end
    n_vec++; if (do1 !== 32'hF0F0F0F0) begin n_err++; $display("FAIL flush_data_hold: got %0h want f0f0f0f0", do1); end
    n_vec++; if (cnt1 !== 32'd4) begin n_err++; $display("FAIL flush_cnt: got %0h want 4", cnt1); end
    or1 = 1;
    step();
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL flush_ov_later: got %0h want 0", ov1); end
    n_vec++; if (cnt1 !== 32'd4) begin n_err++; $display("FAIL flush_cnt_later: got %0h want 4", cnt1); end
    // Flush in the same cycle as a delivery: the delivered beat still retires
    or1 = 0; iv1 = 1; rd1 = 5'd13; d1 = 32'hF3F3F3F3;
    step();
    iv1 = 0; or1 = 1; f1 = 1;
    step();
    f1 = 0;
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL flush_dlv_ov: got %0h want 0", ov1); end
    n_vec++; if (cnt1 !== 32'd5) begin n_err++; $display("FAIL flush_dlv_cnt: got %0h want 5", cnt1); end
  endtask

  task automatic test_async_reset();
    or1 = 0; iv1 = 1; lv1 = 1; rw1 = 1; rd1 = 5'd20; d1 = 32'h12345678;
    step();
    rd1 = 5'd21; d1 = 32'h9ABCDEF0;
    step();
    iv1 = 0;
    n_vec++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL areset_full: got %0h want 0", ir1); end
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL areset_ov: got %0h want 0", ov1); end
    n_vec++; if (lvo1 !== 1'b0) begin n_err++; $display("FAIL areset_lvo: got %0h want 0", lvo1); end
    n_vec++; if (rwo1 !== 1'b0) begin n_err++; $display("FAIL areset_rwo: got %0h want 0", rwo1); end
    n_vec++; if (rdo1 !== 5'd0) begin n_err++; $display("FAIL areset_rd: got %0h want 0", rdo1); end
    n_vec++; if (do1 !== 32'd0) begin n_err++; $display("FAIL areset_data: got %0h want 0", do1); end
    n_vec++; if (cnt1 !== 32'd0) begin n_err++; $display("FAIL areset_cnt: got %0h want 0", cnt1); end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_vec++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL areset_ir: got %0h want 1", ir1); end
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL areset_ov_after: got %0h want 0", ov1); end
  endtask

  task automatic test_lane_rules();
    or2 = 1; iv2 = 1; lv2 = 2'b11; rw2 = 2'b11;
    rd2 = {5'd7, 5'd0}; d2 = {32'h77770001, 32'h0BAD0000};
    step();
    n_vec++; if (rwo2 !== 2'b10) begin n_err++; $display("FAIL lanes_x0_rw: got %0h want 2", rwo2); end
    n_vec++; if (lvo2 !== 2'b11) begin n_err++; $display("FAIL lanes_x0_lv: got %0h want 3", lvo2); end
    rd2 = {5'd9, 5'd9}; d2 = {32'h99990001, 32'h99990000};
    step();
    n_vec++; if (rwo2 !== 2'b10) begin n_err++; $display("FAIL lanes_same_rw: got %0h want 2", rwo2); end
    n_vec++; if (rdo2 !== {5'd9, 5'd9}) begin n_err++; $display("FAIL lanes_same_rd: got %0h want 129", rdo2); end
    n_vec++; if (do2[63:32] !== 32'h99990001) begin n_err++; $display("FAIL lanes_same_data1: got %0h want 99990001", do2[63:32]); end
    lv2 = 2'b01; rd2 = {5'd3, 5'd4}; d2 = {32'h33330001, 32'h44440000};
    step();
    n_vec++; if (rwo2 !== 2'b01) begin n_err++; $display("FAIL lanes_inv_rw: got %0h want 1", rwo2); end
    n_vec++; if (lvo2 !== 2'b01) begin n_err++; $display("FAIL lanes_inv_lv: got %0h want 1", lvo2); end
    lv2 = 2'b11; rw2 = 2'b01; rd2 = {5'd5, 5'd5}; d2 = {32'h55550001, 32'h55550000};
    step();
    iv2 = 0;
    n_vec++; if (rwo2 !== 2'b01) begin n_err++; $display("FAIL lanes_same_nowr_rw: got %0h want 1", rwo2); end
    step();
    n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL lanes_ov_drain: got %0h want 0", ov2); end
    n_vec++; if (cnt2 !== 4'd7) begin n_err++; $display("FAIL lanes_cnt: got %0h want 7", cnt2); end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    or2 = 1; iv2 = 1; lv2 = 2'b11; rw2 = 2'b11; rd2 = {5'd2, 5'd1};
    for (int i = 0; i < 8; i++) begin
      d2 = {32'(i), 32'(i + 100)};
      step();
    end
    n_vec++; if (cnt2 !== 4'd14) begin n_err++; $display("FAIL wrap_cnt_7: got %0h want e", cnt2); end
    iv2 = 0;
    step();
    n_vec++; if (cnt2 !== 4'd0) begin n_err++; $display("FAIL wrap_cnt_8: got %0h want 0", cnt2); end
    n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL wrap_ov: got %0h want 0", ov2); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_lane_rules();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
